// File: rtl/uart_pkg.sv
`default_nettype none
// ==========================================================================
// uart_pkg : shared FSM state type and byte-framing constants
// Rev 1.0
// ==========================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_IDLE = 2'd3
  } sched_state_t;

  localparam logic [4:0] HDR_MARKER     = 5'b10100;
  localparam logic [1:0] BYTES_NO_HDR   = 2'd2;
  localparam logic [1:0] BYTES_WITH_HDR = 2'd3;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ==========================================================================
// rr_arbiter : combinational round-robin pick, search starts at last+1
// Rev 1.0
// ==========================================================================
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    // Offset N_REQ wraps back to last itself, so it is served only when alone.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % N_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ==========================================================================
// uart_tx_scheduler : round-robin sharing of one UART transmitter; words
// go out MSB byte first. Optional UART_SCHED_ID_HEADER_EN adds an id byte.
// Rev 1.0
// ==========================================================================
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int BUSY_TO = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [16*N_REQ-1:0]      req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     done,
  output logic [$clog2(N_REQ)-1:0] done_id,
  output logic                     err,
  output logic [7:0]               tx_data,
  output logic                     tx_wr,
  output logic                     tx_en,
  input  logic                     tx_busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BUSY_TO + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(BUSY_TO);
`ifdef UART_SCHED_ID_HEADER_EN
  localparam logic [1:0] WORD_BYTES = BYTES_WITH_HDR;
`else
  localparam logic [1:0] WORD_BYTES = BYTES_NO_HDR;
`endif

  sched_state_t     state, state_nxt;
  logic [IDX_W-1:0] last, last_nxt;
  logic [IDX_W-1:0] id, id_nxt;
  logic [IDX_W-1:0] done_id_nxt;
  logic [15:0]      word, word_nxt;
  logic [1:0]       bcnt, bcnt_nxt;
  logic [CNT_W-1:0] tocnt, tocnt_nxt, tocnt_inc;
  logic [N_REQ-1:0] gnt_nxt, arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             done_nxt, err_nxt, tx_wr_nxt;
  logic [7:0]       tx_data_nxt, cur_byte;
  logic [15:0]      req_word [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_word[i] = req_data[16*i +: 16];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req  (req),
    .last (last),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  assign tocnt_inc = (tocnt == TO_LIMIT) ? tocnt : tocnt + CNT_W'(1);

  // The remaining-byte count doubles as the byte selector.
`ifdef UART_SCHED_ID_HEADER_EN
  always_comb begin
    case (bcnt)
      BYTES_WITH_HDR: cur_byte = {HDR_MARKER, 3'(id)};
      BYTES_NO_HDR:   cur_byte = word[15:8];
      default:        cur_byte = word[7:0];
    endcase
  end
`else
  assign cur_byte = (bcnt == BYTES_NO_HDR) ? word[15:8] : word[7:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      last    <= IDX_W'(N_REQ - 1);
      id      <= '0;
      word    <= '0;
      bcnt    <= '0;
      tocnt   <= '0;
      gnt     <= '0;
      done    <= 1'b0;
      done_id <= '0;
      err     <= 1'b0;
      tx_data <= '0;
      tx_wr   <= 1'b0;
      tx_en   <= 1'b0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      id      <= id_nxt;
      word    <= word_nxt;
      bcnt    <= bcnt_nxt;
      tocnt   <= tocnt_nxt;
      gnt     <= gnt_nxt;
      done    <= done_nxt;
      done_id <= done_id_nxt;
      err     <= err_nxt;
      tx_data <= tx_data_nxt;
      tx_wr   <= tx_wr_nxt;
      tx_en   <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    id_nxt      = id;
    word_nxt    = word;
    bcnt_nxt    = bcnt;
    tocnt_nxt   = tocnt;
    gnt_nxt     = '0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    done_id_nxt = done_id;
    tx_data_nxt = tx_data;
    tx_wr_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          gnt_nxt   = arb_gnt;
          last_nxt  = arb_idx;
          id_nxt    = arb_idx;
          word_nxt  = req_word[arb_idx];
          bcnt_nxt  = WORD_BYTES;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_data_nxt = cur_byte;
          tx_wr_nxt   = 1'b1;
          tocnt_nxt   = '0;
          state_nxt   = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = ST_WAIT_IDLE;
        end else begin
          tocnt_nxt = tocnt_inc;
          if (tocnt_inc == TO_LIMIT) begin
            err_nxt     = 1'b1;
            done_id_nxt = id;
            state_nxt   = ST_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (!tx_busy) begin
          bcnt_nxt = bcnt - 2'd1;
          if (bcnt != 2'd1) begin
            state_nxt = ST_SEND;
          end else begin
            done_nxt    = 1'b1;
            done_id_nxt = id;
            state_nxt   = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ==========================================================================
// tb_uart_tx_scheduler : scoreboard bench with a simple transmitter model
// Rev 1.0
// ==========================================================================
module tb_uart_tx_scheduler;

  localparam int N_REQ    = 4;
  localparam int BUSY_TO  = 64;
  localparam int BUSY_CYC = 10;

  typedef enum int {EV_GNT, EV_BYTE, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
    int       gap;   // cycles since previous observed event; 0 = any
  } ev_t;
  typedef enum int {TX_NORMAL, TX_STUCK, TX_HOLD} tx_mode_t;

  logic                clk;
  logic                reset;
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    gnt;
  logic                done;
  logic [1:0]          done_id;
  logic                err;
  logic [7:0]          tx_data;
  logic                tx_wr;
  logic                tx_en;
  logic                tx_busy;

  ev_t      exp_q[$];
  int       errors = 0;
  int       checks = 0;
  int       cyc = 0;
  int       last_ev_cyc = 0;
  int       busy_cnt = 0;
  tx_mode_t mode = TX_NORMAL;
  bit       prev_wr = 1'b0;
  bit       busy_seen = 1'b0;

  uart_tx_scheduler #(
    .N_REQ   (N_REQ),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .done_id  (done_id),
    .err      (err),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_en    (tx_en),
    .tx_busy  (tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic observe(input ev_kind_t kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got 0x%0h with nothing pending", kind.name(), val);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check($sformatf("%s_value", e.kind.name()), val, e.val);
      if (e.gap != 0)
        check($sformatf("%s_gap", e.kind.name()), cyc - last_ev_cyc, e.gap);
    end
    last_ev_cyc = cyc;
  endtask

  // Monitor: samples on the falling edge, pops and compares every output pulse.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin
        check("gnt_onehot", $countones(gnt), 1);
        observe(EV_GNT, onehot_idx(gnt));
      end
      if (tx_wr) begin
        check("wr_back_to_back", prev_wr, 0);
        check("wr_while_busy", busy_seen, 0);
        observe(EV_BYTE, tx_data);
      end
      if (done) observe(EV_DONE, done_id);
      if (err)  observe(EV_ERR, done_id);
      prev_wr   = tx_wr;
      busy_seen = tx_busy;
    end
  end

  function automatic void push(input ev_kind_t k, input int v, input int g);
    exp_q.push_back('{kind: k, val: v, gap: g});
  endfunction

  function automatic void push_first(input int id, input logic [15:0] w,
                                     input int gnt_gap, input int first_gap);
    push(EV_GNT, id, gnt_gap);
`ifdef UART_SCHED_ID_HEADER_EN
    push(EV_BYTE, 8'hA0 + id, first_gap);
`else
    push(EV_BYTE, w[15:8], first_gap);
`endif
  endfunction

  // Transmitter model: busy for BUSY_CYC cycles after each strobe.
  function automatic void push_word(input int id, input logic [15:0] w,
                                    input int gnt_gap, input int first_gap);
    push_first(id, w, gnt_gap, first_gap);
`ifdef UART_SCHED_ID_HEADER_EN
    push(EV_BYTE, w[15:8], 12);
`endif
    push(EV_BYTE, w[7:0], 12);
    push(EV_DONE, id, 11);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    req = req & ~gnt;
    if (mode == TX_STUCK && err) mode = TX_NORMAL;  // stuck for one word only
    case (mode)
      TX_STUCK: begin
        busy_cnt = 0;
        tx_busy  = 1'b0;
      end
      TX_HOLD: tx_busy = 1'b1;
      default: begin
        if (tx_wr) busy_cnt = BUSY_CYC;
        else if (busy_cnt > 0) busy_cnt--;
        tx_busy = (busy_cnt != 0);
      end
    endcase
  endtask

  task automatic run_until_empty(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d events pending after %0d cycles, required 0",
               name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  initial begin
    reset    = 1'b0;
    req      = '0;
    req_data = '0;
    tx_busy  = 1'b0;
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {gnt, done, done_id, err, tx_data, tx_wr, tx_en}, 0);
    reset = 1'b0;
    tick();
    check("tx_en_after_reset", tx_en, 1);

    // All four requesting: grants 0,1,2,3, words never interleaved.
    req_data = {16'h7788, 16'h5566, 16'h3344, 16'h1122};
    req      = 4'b1111;
    push_word(0, 16'h1122, 0, 1);
    push_word(1, 16'h3344, 1, 1);
    push_word(2, 16'h5566, 1, 1);
    push_word(3, 16'h7788, 1, 1);
    run_until_empty("all_four", 600);

    // Single request from requester 2.
    req_data[47:32] = 16'hA55A;
    req             = 4'b0100;
    push_word(2, 16'hA55A, 0, 1);
    run_until_empty("single", 200);

    // Stuck transmitter on requester 1's word, then requester 2 served.
    mode            = TX_STUCK;
    req_data[31:16] = 16'hBEEF;
    req_data[47:32] = 16'hCAFE;
    req             = 4'b0110;
    push_first(1, 16'hBEEF, 0, 1);
    push(EV_ERR, 1, BUSY_TO);
    push_word(2, 16'hCAFE, 1, 1);
    run_until_empty("stuck", 600);

    // Transmitter busy at grant for 20 cycles.
    mode            = TX_HOLD;
    tx_busy         = 1'b1;
    req_data[63:48] = 16'hC33C;
    req             = 4'b1000;
    push_word(3, 16'hC33C, 0, 21);
    repeat (20) tick();
    mode = TX_NORMAL;
    run_until_empty("hold_busy", 300);

    // Reset during WAIT_IDLE after the first byte.
    req_data[31:16] = 16'h1357;
    req             = 4'b0010;
    push_first(1, 16'h1357, 0, 1);
    run_until_empty("mid_first", 100);
    repeat (3) tick();
    reset    = 1'b1;
    req      = '0;
    busy_cnt = 0;
    tx_busy  = 1'b0;
    #1;
    check("reset_mid_outputs", {gnt, done, done_id, err, tx_data, tx_wr, tx_en}, 0);
    repeat (2) tick();
    reset           = 1'b0;
    req_data[15:0]  = 16'h2468;
    req_data[63:48] = 16'h9BDF;
    req             = 4'b1001;
    push_word(0, 16'h2468, 0, 1);
    push_word(3, 16'h9BDF, 1, 1);
    run_until_empty("after_reset", 300);

`ifdef UART_SCHED_ID_HEADER_EN
    // Header byte {10100, id}: requester 3 -> A3, then 12, 34.
    req_data[63:48] = 16'h1234;
    req             = 4'b1000;
    push(EV_GNT, 3, 0);
    push(EV_BYTE, 8'hA3, 1);
    push(EV_BYTE, 8'h12, 12);
    push(EV_BYTE, 8'h34, 12);
    push(EV_DONE, 3, 11);
    run_until_empty("header", 200);
`endif

    repeat (20) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
